// File: rtl/wb_dma_copy.sv
// rtl/wb_dma_copy.sv - Wishbone block-copy initiator: burst read into a buffer, burst write back out.
module wb_dma_copy #(
    parameter int BURST_LEN = 4,
    parameter int LEN_W     = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [31:0]      src_adr,
    input  logic [31:0]      dst_adr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    output logic [2:0]       wbm_cti_o,
    output logic [3:0]       wbm_sel_o,
    output logic             wbm_we_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    input  logic             wbm_ack_i
);

    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int IDX_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RGAP,
        S_WR,
        S_WGAP,
        S_DONE
    } state_t;

    state_t              state, state_n;
    logic [BEAT_W-1:0]   beat, beat_n;
    logic [BEAT_W-1:0]   chunk, chunk_n;
    logic [LEN_W-1:0]    remain, remain_n;
    logic [31:0]         src_ptr, src_n;
    logic [31:0]         dst_ptr, dst_n;

    logic [31:0]         data_buf [BURST_LEN];

    logic                rd_n, wr_n;
    logic                cyc_n, we_n, busy_n, done_n;
    logic [31:0]         adr_n, dat_n;
    logic [2:0]          cti_n;

    logic                ack_ok;
    logic                last_beat;

    // A stray ack outside an active cycle must never advance the engine.
    assign ack_ok    = wbm_ack_i && wbm_cyc_o;
    assign last_beat = (beat == chunk - 1'b1);
    assign wbm_sel_o = 4'hF;

    function automatic logic [BEAT_W-1:0] chunk_of(input logic [LEN_W-1:0] r);
        if (r >= LEN_W'(BURST_LEN)) begin
            return BEAT_W'(BURST_LEN);
        end
        return r[BEAT_W-1:0];
    endfunction

    always_comb begin
        state_n  = state;
        beat_n   = beat;
        chunk_n  = chunk;
        remain_n = remain;
        src_n    = src_ptr;
        dst_n    = dst_ptr;
        case (state)
            S_IDLE: begin
                if (start) begin
                    src_n    = {src_adr[31:2], 2'b00};
                    dst_n    = {dst_adr[31:2], 2'b00};
                    remain_n = len;
                    beat_n   = '0;
                    if (len == '0) begin
                        state_n = S_DONE;
                    end else begin
                        chunk_n = chunk_of(len);
                        state_n = S_RD;
                    end
                end
            end
            S_RD: begin
                if (ack_ok) begin
                    src_n = src_ptr + 32'd4;
                    if (last_beat) begin
                        beat_n  = '0;
                        state_n = S_RGAP;
                    end else begin
                        beat_n = beat + 1'b1;
                    end
                end
            end
            S_RGAP: begin
                beat_n  = '0;
                state_n = S_WR;
            end
            S_WR: begin
                if (ack_ok) begin
                    dst_n = dst_ptr + 32'd4;
                    if (last_beat) begin
                        beat_n   = '0;
                        remain_n = remain - LEN_W'(chunk);
                        state_n  = (remain_n == '0) ? S_DONE : S_WGAP;
                    end else begin
                        beat_n = beat + 1'b1;
                    end
                end
            end
            S_WGAP: begin
                chunk_n = chunk_of(remain);
                state_n = S_RD;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Bus outputs are decoded from next-state values so they register in step with the FSM.
    always_comb begin
        rd_n   = (state_n == S_RD);
        wr_n   = (state_n == S_WR);
        cyc_n  = rd_n || wr_n;
        we_n   = wr_n;
        busy_n = (state_n != S_IDLE);
        done_n = (state_n == S_DONE);
        adr_n  = 32'd0;
        dat_n  = 32'd0;
        cti_n  = 3'b000;
        if (rd_n) begin
            adr_n = src_n;
        end else if (wr_n) begin
            adr_n = dst_n;
            dat_n = data_buf[beat_n[IDX_W-1:0]];
        end
        if (cyc_n) begin
            cti_n = (beat_n == chunk_n - 1'b1) ? 3'b111 : 3'b010;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= S_IDLE;
            beat    <= '0;
            chunk   <= '0;
            remain  <= '0;
            src_ptr <= 32'd0;
            dst_ptr <= 32'd0;
        end else begin
            state   <= state_n;
            beat    <= beat_n;
            chunk   <= chunk_n;
            remain  <= remain_n;
            src_ptr <= src_n;
            dst_ptr <= dst_n;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= 32'd0;
            wbm_dat_o <= 32'd0;
            wbm_cti_o <= 3'b000;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            wbm_cyc_o <= cyc_n;
            wbm_stb_o <= cyc_n;
            wbm_we_o  <= we_n;
            wbm_adr_o <= adr_n;
            wbm_dat_o <= dat_n;
            wbm_cti_o <= cti_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (state == S_RD && ack_ok) begin
            data_buf[beat[IDX_W-1:0]] <= wbm_dat_i;
        end
    end

endmodule

// File: tb/tb_wb_dma_copy.sv
// tb/tb_wb_dma_copy.sv - directed self-checking bench for wb_dma_copy against a word memory slave.
module tb_wb_dma_copy;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic [31:0] src_adr;
    logic [31:0] dst_adr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic [2:0]  wbm_cti_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        ack;

    always #5 sys_clk = ~sys_clk;

    wb_dma_copy #(.BURST_LEN(4), .LEN_W(16)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .src_adr   (src_adr),
        .dst_adr   (dst_adr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_cti_o (wbm_cti_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_ack_i (ack)
    );

    int checks = 0;
    int fails = 0;
    int cycle = 0;
    int start_cycle = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int cyc_high_cnt = 0;
    int wait_cnt = 0;
    bit rand_wait = 1'b0;
    logic mem_ready = 1'b0;
    logic [31:0] mem [1024];

    int          b_cyc[$];
    logic [31:0] b_adr[$];
    logic [31:0] b_dat[$];
    logic        b_we[$];
    logic [2:0]  b_cti[$];
    int          e_cyc[$];
    logic [31:0] e_adr[$];
    logic [31:0] e_dat[$];
    logic        e_we[$];
    logic [2:0]  e_cti[$];

    // Memory word i initially holds 0xD0000000 + i.
    assign ack       = wbm_cyc_o && wbm_stb_o && (wait_cnt == 0);
    assign wbm_dat_i = mem[wbm_adr_o[11:2]];

    always @(posedge sys_clk) begin
        cycle <= cycle + 1;
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hD000_0000 + i;
            mem_ready <= 1'b1;
        end else if (ack && wbm_we_o) begin
            mem[wbm_adr_o[11:2]] <= wbm_dat_o;
        end
        if (!sys_rst_n) wait_cnt <= 0;
        else if (ack) wait_cnt <= rand_wait ? int'($urandom_range(0, 3)) : 0;
        else if (wbm_cyc_o && wbm_stb_o) wait_cnt <= wait_cnt - 1;
        else wait_cnt <= 0;
    end

    logic        prev_wait = 1'b0;
    logic [67:0] prev_bus = '0;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            prev_wait <= 1'b0;
        end else begin
            if (prev_wait && wbm_stb_o) begin
                checks++;
                if ({wbm_adr_o, wbm_dat_o, wbm_cti_o, wbm_we_o} !== prev_bus) begin
                    fails++;
                    $display("FAIL stall_stable: got %h expected %h", {wbm_adr_o, wbm_dat_o, wbm_cti_o, wbm_we_o}, prev_bus);
                end
            end
            prev_wait <= wbm_stb_o && !ack;
            prev_bus  <= {wbm_adr_o, wbm_dat_o, wbm_cti_o, wbm_we_o};
            if (wbm_cyc_o) cyc_high_cnt++;
            if (ack) begin
                b_cyc.push_back(cycle - start_cycle);
                b_adr.push_back(wbm_adr_o);
                b_dat.push_back(wbm_we_o ? wbm_dat_o : wbm_dat_i);
                b_we.push_back(wbm_we_o);
                b_cti.push_back(wbm_cti_o);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cycle - start_cycle;
            end
        end
    end

    task automatic exp_clear();
        e_cyc.delete(); e_adr.delete(); e_dat.delete(); e_we.delete(); e_cti.delete();
    endtask

    task automatic exp_beat(input logic [31:0] a, input logic w, input logic [2:0] c, input logic [31:0] d, input int cy);
        e_adr.push_back(a); e_we.push_back(w); e_cti.push_back(c); e_dat.push_back(d); e_cyc.push_back(cy);
    endtask

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n, output bit timeout);
        int base;
        b_cyc.delete(); b_adr.delete(); b_dat.delete(); b_we.delete(); b_cti.delete();
        @(negedge sys_clk); #1;
        cyc_high_cnt = 0;
        src_adr = s; dst_adr = d; len = n; start = 1'b1;
        start_cycle = cycle;
        base = done_cnt;
        timeout = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge sys_clk); #1;
            start = 1'b0;
            if (done_cnt != base) begin
                timeout = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; start = 1'b0; src_adr = '0; dst_adr = '0; len = '0;
        repeat (3) @(negedge sys_clk);
        #1;
        checks++;
        if ({busy, done, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_cti_o} !== 72'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0", {busy, done, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_cti_o});
        end
        checks++;
        if (wbm_sel_o !== 4'hF) begin
            fails++;
            $display("FAIL reset_sel: got %h expected f", wbm_sel_o);
        end
        sys_rst_n = 1'b1;
    endtask

    task automatic test_len4();
        bit to;
        int n;
        run_copy(32'h100, 32'h200, 16'd4, to);
        exp_clear();
        for (int i = 0; i < 4; i++) exp_beat(32'h100 + 4 * i, 1'b0, (i == 3) ? 3'b111 : 3'b010, 32'hD000_0040 + i, 1 + i);
        for (int i = 0; i < 4; i++) exp_beat(32'h200 + 4 * i, 1'b1, (i == 3) ? 3'b111 : 3'b010, 32'hD000_0040 + i, 6 + i);
        checks++;
        if (to || done_cyc != 10) begin
            fails++;
            $display("FAIL len4_done_cycle: got %0d (timeout %0d) expected 10", done_cyc, to);
        end
        checks++;
        if (b_adr.size() != e_adr.size() || cyc_high_cnt != 8) begin
            fails++;
            $display("FAIL len4_beats: got %0d beats %0d cyc-high expected 8 8", b_adr.size(), cyc_high_cnt);
        end
        n = (b_adr.size() < e_adr.size()) ? b_adr.size() : e_adr.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if ({b_adr[i], b_we[i], b_cti[i], b_dat[i]} !== {e_adr[i], e_we[i], e_cti[i], e_dat[i]} || b_cyc[i] != e_cyc[i]) begin
                fails++;
                $display("FAIL len4_beat%0d: got %h/%0d/%b/%h @%0d expected %h/%0d/%b/%h @%0d", i,
                         b_adr[i], b_we[i], b_cti[i], b_dat[i], b_cyc[i], e_adr[i], e_we[i], e_cti[i], e_dat[i], e_cyc[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[10'h080 + i] !== 32'hD000_0040 + i) begin
                fails++;
                $display("FAIL len4_mem%0d: got %h expected %h", i, mem[10'h080 + i], 32'hD000_0040 + i);
            end
        end
    endtask

    task automatic test_len6();
        bit to;
        int n;
        run_copy(32'h100, 32'h300, 16'd6, to);
        exp_clear();
        for (int i = 0; i < 4; i++) exp_beat(32'h100 + 4 * i, 1'b0, (i == 3) ? 3'b111 : 3'b010, 32'hD000_0040 + i, 1 + i);
        for (int i = 0; i < 4; i++) exp_beat(32'h300 + 4 * i, 1'b1, (i == 3) ? 3'b111 : 3'b010, 32'hD000_0040 + i, 6 + i);
        exp_beat(32'h110, 1'b0, 3'b010, 32'hD000_0044, 11);
        exp_beat(32'h114, 1'b0, 3'b111, 32'hD000_0045, 12);
        exp_beat(32'h310, 1'b1, 3'b010, 32'hD000_0044, 14);
        exp_beat(32'h314, 1'b1, 3'b111, 32'hD000_0045, 15);
        checks++;
        if (to || done_cyc != 16) begin
            fails++;
            $display("FAIL len6_done_cycle: got %0d (timeout %0d) expected 16", done_cyc, to);
        end
        checks++;
        if (b_adr.size() != e_adr.size()) begin
            fails++;
            $display("FAIL len6_beat_count: got %0d expected %0d", b_adr.size(), e_adr.size());
        end
        n = (b_adr.size() < e_adr.size()) ? b_adr.size() : e_adr.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if ({b_adr[i], b_we[i], b_cti[i], b_dat[i]} !== {e_adr[i], e_we[i], e_cti[i], e_dat[i]} || b_cyc[i] != e_cyc[i]) begin
                fails++;
                $display("FAIL len6_beat%0d: got %h/%0d/%b/%h @%0d expected %h/%0d/%b/%h @%0d", i,
                         b_adr[i], b_we[i], b_cti[i], b_dat[i], b_cyc[i], e_adr[i], e_we[i], e_cti[i], e_dat[i], e_cyc[i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mem[10'h0C0 + i] !== 32'hD000_0040 + i) begin
                fails++;
                $display("FAIL len6_mem%0d: got %h expected %h", i, mem[10'h0C0 + i], 32'hD000_0040 + i);
            end
        end
    endtask

    task automatic test_len1();
        bit to;
        run_copy(32'h10B, 32'h703, 16'd1, to);
        checks++;
        if (to || done_cyc != 4) begin
            fails++;
            $display("FAIL len1_done_cycle: got %0d (timeout %0d) expected 4", done_cyc, to);
        end
        checks++;
        if (b_adr.size() != 2) begin
            fails++;
            $display("FAIL len1_beat_count: got %0d expected 2", b_adr.size());
        end else begin
            checks++;
            if ({b_adr[0], b_we[0], b_cti[0], b_dat[0]} !== {32'h108, 1'b0, 3'b111, 32'hD000_0042} || b_cyc[0] != 1) begin
                fails++;
                $display("FAIL len1_read: got %h/%0d/%b/%h @%0d expected 108/0/111/d0000042 @1", b_adr[0], b_we[0], b_cti[0], b_dat[0], b_cyc[0]);
            end
            checks++;
            if ({b_adr[1], b_we[1], b_cti[1], b_dat[1]} !== {32'h700, 1'b1, 3'b111, 32'hD000_0042} || b_cyc[1] != 3) begin
                fails++;
                $display("FAIL len1_write: got %h/%0d/%b/%h @%0d expected 700/1/111/d0000042 @3", b_adr[1], b_we[1], b_cti[1], b_dat[1], b_cyc[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        run_copy(32'h100, 32'h900, 16'd0, to);
        checks++;
        if (to || done_cyc != 1 || cyc_high_cnt != 0 || b_adr.size() != 0) begin
            fails++;
            $display("FAIL len0: got done@%0d cyc-high %0d beats %0d expected done@1 0 0", done_cyc, cyc_high_cnt, b_adr.size());
        end
        checks++;
        if ({busy, done} !== 2'b11) begin
            fails++;
            $display("FAIL len0_busy_done: got %b expected 11", {busy, done});
        end
        run_copy(32'h100, 32'h900, 16'd1, to);
        checks++;
        if (to || done_cyc != 4 || mem[10'h240] !== 32'hD000_0040) begin
            fails++;
            $display("FAIL b2b_copy: got done@%0d mem %h expected done@4 d0000040", done_cyc, mem[10'h240]);
        end
        @(negedge sys_clk); #1;
        checks++;
        if ({busy, done, wbm_cyc_o} !== 3'b000) begin
            fails++;
            $display("FAIL b2b_idle: got %b expected 000", {busy, done, wbm_cyc_o});
        end
    endtask

    task automatic test_random_wait();
        int base;
        bit to;
        rand_wait = 1'b1;
        @(negedge sys_clk); #1;
        src_adr = 32'h140; dst_adr = 32'h400; len = 16'd7; start = 1'b1;
        start_cycle = cycle;
        base = done_cnt;
        to = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge sys_clk); #1;
            start = (k == 3 || k == 9);
            if (k == 1) begin
                src_adr = 32'h800; dst_adr = 32'hA00; len = 16'd2;
            end
            if (done_cnt != base) begin
                to = 1'b0;
                break;
            end
        end
        start = 1'b0;
        rand_wait = 1'b0;
        repeat (6) @(negedge sys_clk);
        #1;
        checks++;
        if (to || done_cnt != base + 1 || wbm_cyc_o !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rand_done: got timeout %0d dones %0d cyc %b busy %b expected 0 1 0 0", to, done_cnt - base, wbm_cyc_o, busy);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (mem[10'h100 + i] !== 32'hD000_0050 + i) begin
                fails++;
                $display("FAIL rand_mem%0d: got %h expected %h", i, mem[10'h100 + i], 32'hD000_0050 + i);
            end
        end
        checks++;
        if (mem[10'h280] !== 32'hD000_0280) begin
            fails++;
            $display("FAIL rand_ignored_start: got %h expected d0000280", mem[10'h280]);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        @(negedge sys_clk); #1;
        src_adr = 32'h100; dst_adr = 32'h500; len = 16'd4; start = 1'b1;
        start_cycle = cycle;
        base = done_cnt;
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk); #1;
            start = 1'b0;
            if (cycle - start_cycle == 8) break;
        end
        checks++;
        if ({wbm_cyc_o, wbm_we_o, wbm_adr_o} !== {1'b1, 1'b1, 32'h508}) begin
            fails++;
            $display("FAIL midrst_position: got cyc %b we %b adr %h expected 1 1 508", wbm_cyc_o, wbm_we_o, wbm_adr_o);
        end
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, busy, done} !== 5'b00000) begin
            fails++;
            $display("FAIL midrst_async: got %b expected 00000", {wbm_cyc_o, wbm_stb_o, wbm_we_o, busy, done});
        end
        repeat (3) @(negedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        #1;
        checks++;
        if (done_cnt != base || busy !== 1'b0) begin
            fails++;
            $display("FAIL midrst_no_done: got dones %0d busy %b expected 0 0", done_cnt - base, busy);
        end
        checks++;
        if ({mem[10'h140], mem[10'h141], mem[10'h142]} !== {32'hD000_0040, 32'hD000_0041, 32'hD000_0142}) begin
            fails++;
            $display("FAIL midrst_partial: got %h %h %h expected d0000040 d0000041 d0000142", mem[10'h140], mem[10'h141], mem[10'h142]);
        end
    endtask

    task automatic test_wrap();
        bit to;
        logic [31:0] ea [4];
        logic [31:0] ed [4];
        ea[0] = 32'hFFFF_FFF8; ea[1] = 32'hFFFF_FFFC; ea[2] = 32'h0000_0000; ea[3] = 32'h0000_0004;
        ed[0] = 32'hD000_03FE; ed[1] = 32'hD000_03FF; ed[2] = 32'hD000_0000; ed[3] = 32'hD000_0001;
        run_copy(32'hFFFF_FFF8, 32'h600, 16'd4, to);
        checks++;
        if (to || done_cyc != 10 || b_adr.size() != 8) begin
            fails++;
            $display("FAIL wrap_done: got done@%0d beats %0d expected done@10 8", done_cyc, b_adr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({b_adr[i], b_dat[i]} !== {ea[i], ed[i]} || mem[10'h180 + i] !== ed[i]) begin
                    fails++;
                    $display("FAIL wrap_beat%0d: got adr %h dat %h mem %h expected %h %h", i, b_adr[i], b_dat[i], mem[10'h180 + i], ea[i], ed[i]);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_len4();
        test_len6();
        test_len1();
        test_back_to_back();
        test_random_wait();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/wb_dma_copy.md
# wb_dma_copy

Wishbone bus initiator that copies a block of 32-bit words from a source address to a destination address. It plugs into one master port of the shared Wishbone interconnect. Each chunk of up to BURST_LEN words is read with an incrementing burst into an internal buffer, then written back out with a second burst. Between bursts, `cyc` is released for one cycle so the interconnect arbiter can re-grant the bus.

## Interface
- BURST_LEN, 4: words per chunk; a power of two, 1..16.
- LEN_W, 16: width of the word-count input.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_adr  in  32  source byte address; bits [1:0] ignored (treated as 0).
- dst_adr  in  32  destination byte address; bits [1:0] ignored.
- len  in  LEN_W  number of 32-bit words to copy.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at completion.
- wbm_adr_o  out  32  bus byte address.
- wbm_dat_o  out  32  write data; 0 when not writing.
- wbm_dat_i  in  32  read data.
- wbm_cti_o  out  3  cycle type: 010 for a non-final beat, 111 for the final beat of a burst.
- wbm_sel_o  out  4  constant 4'hF.
- wbm_we_o  out  1  write enable.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_ack_i  in  1  slave acknowledge.

## Operation
- States: IDLE, RD, RGAP, WR, WGAP, DONE.
- IDLE + start:
  - latch src/dst with bits [1:0] forced to 0; latch len into `remain`.
  - If len==0, go to DONE with no bus activity.
  - Otherwise set chunk = min(BURST_LEN, remain) and go to RD.
- RD:
  - cyc=stb=1, we=0, adr = src_ptr.
  - Each ack: store wbm_dat_i into buf[beat], beat++, src_ptr += 4.
  - The ack on beat chunk-1 leads to RGAP.
- RGAP: cyc=stb=0 for exactly one cycle, then WR with beat reset to 0.
- WR:
  - cyc=stb=we=1, adr = dst_ptr, dat_o = buf[beat].
  - Each ack: beat++, dst_ptr += 4.
  - On the last ack, remain -= chunk. If remain is now 0, go to DONE; otherwise go to WGAP.
- WGAP: cyc=stb=0 for one cycle; compute the next chunk; go to RD.
- DONE: done=1 for one cycle, then IDLE.
- cti:
  - 111 on beat chunk-1, 010 otherwise.
  - When chunk==1 the only beat is 111.
  - cti is 000 whenever cyc=0.
- Address arithmetic is modulo 2^32; a wrap past 0xFFFFFFFC continues at 0x00000000.
- Wait states: stb stays high and adr/dat/cti stay stable until ack. There is no timeout.
- start is ignored outside IDLE. len, src_adr and dst_adr are not re-sampled while busy.
- A final partial chunk (len not a multiple of BURST_LEN) uses chunk = remain.
- An ack arriving while cyc=0 is ignored.

## Timing
- Reset values: every output is 0 (busy, done, cyc, stb, we, adr, dat_o, cti); sel is 4'hF. State is IDLE; pointers and counters are 0.
- Reset mid-transfer: cyc/stb drop asynchronously on sys_rst_n low. No done is produced, and the partial copy is abandoned.
- All bus outputs are registered.
- start in cycle 0 → cyc/stb high in cycle 1 with adr = src.
- With a zero-wait slave (ack in the same cycle as stb), one beat completes per cycle.
- Latency, zero-wait slave:
  - len=N ≤ BURST_LEN: done in cycle 2N+2.
  - Each additional chunk adds 2·chunk + 2 cycles (RGAP, WGAP).
  - len=0: done in cycle 1.
- busy rises in cycle 1 and falls in the cycle after done (back in IDLE). A new start is accepted in that IDLE cycle.

## Test plan
- BURST_LEN=4, zero-wait memory model, start with src=0x100, dst=0x200, len=4:
  - reads at 0x100..0x10C with cti 010,010,010,111;
  - one cyc-low cycle;
  - writes of the same data at 0x200..0x20C;
  - done in cycle 10.
- len=6, BURST_LEN=4: chunks of 4 then 2; cyc is low for one cycle between each burst. The second read burst starts at 0x110 with cti 010,111. Destination holds all 6 words.
- len=1: a single read beat with cti=111, a single write beat with cti=111, done in cycle 4.
- len=0: done in cycle 1; cyc is never asserted.
- Random ack delays of 0-3 cycles: adr/dat/cti stay stable while stb is high without ack, and the data is copied correctly. start pulses while busy are ignored.
- Drive sys_rst_n low during WR beat 2:
  - cyc/stb/we go to 0 immediately, busy=0, no done;
  - a subsequent start with src=0xFFFFFFF8, len=4 wraps reads to 0x0, 0x4.
